// File: rtl/gal_prog_pkg.sv
// Shared types and counter-width helpers for the GAL fuse-row programming sequencer.
// Optional read-back verify is enabled by defining GAL_PROG_VERIFY_EN.
package gal_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PULSE,
        VSTB,
        VSHIFT
    } state_t;

    localparam int DEF_ROW_BITS     = 64;
    localparam int DEF_CLK_DIV      = 4;
    localparam int DEF_PULSE_CYCLES = 1000;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DIV_W   = cw(DEF_CLK_DIV);
    localparam int BIT_W   = cw(DEF_ROW_BITS + 1);
    localparam int PULSE_W = cw(DEF_PULSE_CYCLES + 1);

endpackage

// File: rtl/gal_prog_shifter.sv
// Row shift register with P_SCLK divider; shifts out on falling phase end,
// samples serial input on each rising phase start (dir=1).
module gal_prog_shifter
    import gal_prog_pkg::*;
#(
    parameter int ROW_BITS = 64,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                dir,
    input  logic [ROW_BITS-1:0] load,
    input  logic                sdin,
    output logic                sclk,
    output logic                sdout,
    output logic [ROW_BITS-1:0] rdata,
    output logic                bit_done,
    output logic                all_done
);

    localparam int DW = cw(CLK_DIV);
    localparam int BW = cw(ROW_BITS + 1);

    logic                active;
    logic                phase;
    logic                dir_q;
    logic [DW-1:0]       div;
    logic [BW-1:0]       nbit;
    logic [ROW_BITS-1:0] sreg;
    logic                tick;

    assign tick     = active && (div == DW'(CLK_DIV - 1));
    assign bit_done = tick && phase;
    assign all_done = bit_done && (nbit == BW'(ROW_BITS - 1));
    assign sclk     = active & phase;
    assign sdout    = active & ~dir_q & sreg[0];
    assign rdata    = sreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            phase  <= 1'b0;
            dir_q  <= 1'b0;
            div    <= '0;
            nbit   <= '0;
            sreg   <= '0;
        end else if (start) begin
            active <= 1'b1;
            phase  <= 1'b0;
            dir_q  <= dir;
            div    <= '0;
            nbit   <= '0;
            sreg   <= dir ? '0 : load;
        end else if (active) begin
            div <= tick ? '0 : div + 1'b1;
            // first sample lands in bit 0 after ROW_BITS right shifts
            if (tick && !phase) begin
                phase <= 1'b1;
                if (dir_q)
                    sreg <= {sdin, sreg[ROW_BITS-1:1]};
            end
            if (bit_done) begin
                phase <= 1'b0;
                if (!dir_q)
                    sreg <= sreg >> 1;
                if (all_done)
                    active <= 1'b0;
                else
                    nbit <= nbit + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gal_prog_sequencer.sv
// GAL fuse-row programming sequencer: shift row, strobe, optional verify.
// Read-back verify (VSTB/VSHIFT, ERR) is built only with GAL_PROG_VERIFY_EN.
module gal_prog_sequencer
    import gal_prog_pkg::*;
#(
    parameter int ROW_BITS     = 64,
    parameter int ADDR_BITS    = 6,
    parameter int CLK_DIV      = 4,
    parameter int PULSE_CYCLES = 1000
) (
    input  logic                 C,
    input  logic                 R_N,
    input  logic                 ROW_VALID,
    output logic                 ROW_READY,
    input  logic [ADDR_BITS-1:0] ROW_ADDR,
    input  logic [ROW_BITS-1:0]  ROW_DATA,
    input  logic                 ROW_LAST,
    input  logic                 ERR_CLR,
    output logic                 P_SCLK,
    output logic                 P_SDOUT,
    input  logic                 P_SDIN,
    output logic [ADDR_BITS-1:0] P_RA,
    output logic                 P_STB,
    output logic                 P_PV,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic [ADDR_BITS-1:0] ERR_ADDR
);

    localparam int CMAX = (PULSE_CYCLES > CLK_DIV) ? PULSE_CYCLES : CLK_DIV;
    localparam int PW   = cw(CMAX + 1);

    state_t              state, state_n;
    logic [PW-1:0]       cnt, cnt_n;
    logic [ROW_BITS-1:0] data_q;
    logic [ROW_BITS-1:0] rdata;
    logic                last_q;
    logic                start, dir, mism;
    logic                sh_bit, sh_all;

    assign ROW_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign P_STB     = (state == PULSE) || (state == VSTB);
    assign P_PV      = (state == PULSE);

    gal_prog_shifter #(
        .ROW_BITS (ROW_BITS),
        .CLK_DIV  (CLK_DIV)
    ) u_shift (
        .clk      (C),
        .rst_n    (R_N),
        .start    (start),
        .dir      (dir),
        .load     (ROW_DATA),
        .sdin     (P_SDIN),
        .sclk     (P_SCLK),
        .sdout    (P_SDOUT),
        .rdata    (rdata),
        .bit_done (sh_bit),
        .all_done (sh_all)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        start   = 1'b0;
        dir     = 1'b0;
        mism    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ROW_VALID) begin
                    state_n = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (sh_all)
                    state_n = PULSE;
            end
            PULSE: begin
                if (cnt == PW'(PULSE_CYCLES - 1)) begin
                    cnt_n = '0;
`ifdef GAL_PROG_VERIFY_EN
                    state_n = VSTB;
`else
                    state_n = IDLE;
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef GAL_PROG_VERIFY_EN
            VSTB: begin
                // shifter start lines up with the first VSHIFT cycle
                if (cnt == PW'(CLK_DIV - 1)) begin
                    cnt_n   = '0;
                    state_n = VSHIFT;
                    start   = 1'b1;
                    dir     = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            VSHIFT: begin
                if (sh_all) begin
                    state_n = IDLE;
                    mism    = (rdata != data_q);
                end
            end
`else
            VSTB:    state_n = IDLE;
            VSHIFT:  state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            P_RA   <= '0;
            DONE   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            DONE  <= BUSY && (state_n == IDLE) && last_q;
            if (ROW_VALID && ROW_READY) begin
                data_q <= ROW_DATA;
                last_q <= ROW_LAST;
                P_RA   <= ROW_ADDR;
            end
        end
    end

`ifdef GAL_PROG_VERIFY_EN
    logic unused;
    assign unused = sh_bit;

    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            ERR      <= 1'b0;
            ERR_ADDR <= '0;
        end else if (mism) begin
            ERR <= 1'b1;
            if (!ERR)
                ERR_ADDR <= P_RA;
        end else if (ERR_CLR) begin
            ERR <= 1'b0;
        end
    end
`else
    logic unused;
    assign unused   = ^{ERR_CLR, rdata, data_q, mism, sh_bit};
    assign ERR      = 1'b0;
    assign ERR_ADDR = '0;
`endif

endmodule

// File: tb/tb_gal_prog_sequencer.sv
// Randomized self-checking bench for gal_prog_sequencer.
// Build with GAL_PROG_VERIFY_EN to exercise read-back verify as well.
module tb_gal_prog_sequencer;

    localparam int RB = 8;
    localparam int AB = 4;
    localparam int CD = 2;
    localparam int PC = 10;
    localparam int SHIFT_CYC = 2 * CD * RB;
`ifdef GAL_PROG_VERIFY_EN
    localparam bit VER = 1'b1;
    localparam int BUSY_CYC = 2 * SHIFT_CYC + PC + CD;
`else
    localparam bit VER = 1'b0;
    localparam int BUSY_CYC = SHIFT_CYC + PC;
`endif

    logic          C, R_N;
    logic          ROW_VALID, ROW_READY;
    logic [AB-1:0] ROW_ADDR;
    logic [RB-1:0] ROW_DATA;
    logic          ROW_LAST, ERR_CLR;
    logic          P_SCLK, P_SDOUT, P_SDIN;
    logic [AB-1:0] P_RA;
    logic          P_STB, P_PV, BUSY, DONE, ERR;
    logic [AB-1:0] ERR_ADDR;

    gal_prog_sequencer #(
        .ROW_BITS     (RB),
        .ADDR_BITS    (AB),
        .CLK_DIV      (CD),
        .PULSE_CYCLES (PC)
    ) dut (
        .C         (C),
        .R_N       (R_N),
        .ROW_VALID (ROW_VALID),
        .ROW_READY (ROW_READY),
        .ROW_ADDR  (ROW_ADDR),
        .ROW_DATA  (ROW_DATA),
        .ROW_LAST  (ROW_LAST),
        .ERR_CLR   (ERR_CLR),
        .P_SCLK    (P_SCLK),
        .P_SDOUT   (P_SDOUT),
        .P_SDIN    (P_SDIN),
        .P_RA      (P_RA),
        .P_STB     (P_STB),
        .P_PV      (P_PV),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .ERR_ADDR  (ERR_ADDR)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    typedef struct {
        logic [AB-1:0] a;
        logic [RB-1:0] d;
        logic          l;
        logic [RB-1:0] rb;
        logic          clr;
    } row_t;

    row_t          rows[$];
    int            checks = 0;
    int            failures = 0;
    logic          merr = 1'b0;
    logic [AB-1:0] mea = '0;
    logic [RB-1:0] rb_cur = '0;
    logic [3:0]    vidx = '0;

`ifdef GAL_PROG_VERIFY_EN
    // device model: returns rb_cur bit by bit, one per rising P_SCLK
    always @(posedge P_SCLK or posedge P_STB)
        if (P_STB) vidx = '0;
        else vidx = vidx + 1'b1;
    assign P_SDIN = rb_cur[vidx[2:0]];
`else
    initial forever begin
        @(negedge C);
        P_SDIN = 1'($urandom);
    end
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic present(input row_t r);
        ROW_VALID = 1'b1;
        ROW_ADDR  = r.a;
        ROW_DATA  = r.d;
        ROW_LAST  = r.l;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic run_rows(input bit b2b);
        int n;
        n = rows.size();
        @(negedge C);
        if (rows[0].clr) begin
            ERR_CLR = 1'b1;
            @(negedge C);
            ERR_CLR = 1'b0;
            merr = 1'b0;
        end
        present(rows[0]);
        for (int i = 0; i < n; i++) begin
            row_t r;
            int cyc, ro, rv, shc, stc, vsc;
            int rabad, pvbad, rdybad, doneb;
            logic [RB-1:0] ob;
            logic prev;
            r = rows[i];
            cyc = 0; ro = 0; rv = 0; shc = 0; stc = 0; vsc = 0;
            rabad = 0; pvbad = 0; rdybad = 0; doneb = 0;
            ob = '0; prev = 1'b0;
            checks++;
            if (ROW_READY !== 1'b1) begin
                failures++;
                $display("FAIL ready row%0d got=%b want=1", i, ROW_READY);
            end
            @(negedge C);
            rb_cur = r.rb;
            if (b2b && i < n - 1) present(rows[i+1]);
            else ROW_VALID = 1'b0;
            while (BUSY === 1'b1 && cyc < 400) begin
                cyc++;
                if (P_SCLK === 1'b1 && prev === 1'b0) begin
                    if (stc == 0) begin
                        if (ro < RB) ob[ro] = P_SDOUT;
                        ro++;
                    end else begin
                        rv++;
                    end
                end
                prev = P_SCLK;
                if (P_STB === 1'b1) begin
                    if (P_PV === 1'b1) stc++;
                    else vsc++;
                    if (P_RA !== r.a) rabad++;
                end else if (P_PV !== 1'b0) begin
                    pvbad++;
                end
                if (P_STB !== 1'b1 && stc == 0) shc++;
                if (ROW_READY !== 1'b0) rdybad++;
                if (DONE !== 1'b0) doneb++;
                @(negedge C);
            end
            if (VER && r.rb != r.d) begin
                if (!merr) mea = r.a;
                merr = 1'b1;
            end
            chk($sformatf("busy_cycles r%0d", i), cyc, BUSY_CYC);
            chk($sformatf("shift_cycles r%0d", i), shc, SHIFT_CYC);
            chk($sformatf("sclk_rises r%0d", i), ro, RB);
            chk($sformatf("sdout_bits r%0d", i), int'(ob), int'(r.d));
            chk($sformatf("verify_rises r%0d", i), rv, VER ? RB : 0);
            chk($sformatf("pulse_cycles r%0d", i), stc, PC);
            chk($sformatf("vstb_cycles r%0d", i), vsc, VER ? CD : 0);
            chk($sformatf("ra_in_strobe r%0d", i), rabad, 0);
            chk($sformatf("pv_no_strobe r%0d", i), pvbad, 0);
            chk($sformatf("ready_busy r%0d", i), rdybad, 0);
            chk($sformatf("done_early r%0d", i), doneb, 0);
            chk($sformatf("done r%0d", i), int'(DONE), int'(r.l));
            chk($sformatf("busy_end r%0d", i), int'(BUSY), 0);
            chk($sformatf("pins_idle r%0d", i), int'({P_SCLK, P_SDOUT}), 0);
            chk($sformatf("ra_hold r%0d", i), int'(P_RA), int'(r.a));
            chk($sformatf("err r%0d", i), int'(ERR), int'(merr));
            chk($sformatf("err_addr r%0d", i), int'(ERR_ADDR), int'(mea));
            if (!b2b || i == n - 1) begin
                @(negedge C);
                chk($sformatf("done_drop r%0d", i), int'(DONE), 0);
                repeat ($urandom_range(0, 2)) @(negedge C);
                if (i < n - 1) begin
                    if (rows[i+1].clr) begin
                        ERR_CLR = 1'b1;
                        @(negedge C);
                        ERR_CLR = 1'b0;
                        merr = 1'b0;
                    end
                    present(rows[i+1]);
                end
            end
        end
    endtask

    task automatic test_reset;
        R_N = 1'b0;
        ROW_VALID = 1'b0;
        ROW_ADDR = '0;
        ROW_DATA = '0;
        ROW_LAST = 1'b0;
        ERR_CLR = 1'b0;
        repeat (3) @(negedge C);
        chk("rst_ready", int'(ROW_READY), 1);
        chk("rst_busy_done", int'({BUSY, DONE}), 0);
        chk("rst_pins", int'({P_SCLK, P_SDOUT, P_STB, P_PV}), 0);
        chk("rst_ra", int'(P_RA), 0);
        chk("rst_err", int'({ERR, ERR_ADDR}), 0);
        R_N = 1'b1;
        @(negedge C);
        chk("rel_ready", int'(ROW_READY), 1);
    endtask

    task automatic test_single;
        rows.delete();
        rows.push_back('{a: 4'd5, d: 8'hA5, l: 1'b1, rb: 8'hA5, clr: 1'b0});
        run_rows(1'b0);
    endtask

    task automatic test_random;
        rows.delete();
        for (int i = 0; i < 6; i++) begin
            row_t r;
            r.a = AB'($urandom);
            r.d = RB'($urandom);
            r.l = (i == 5);
            r.rb = ($urandom_range(0, 2) == 0) ?
                   (r.d ^ (8'd1 << $urandom_range(0, 7))) : r.d;
            r.clr = ($urandom_range(0, 2) == 0);
            rows.push_back(r);
        end
        run_rows(1'b0);
    endtask

    task automatic test_back_to_back;
        rows.delete();
        for (int i = 0; i < 4; i++)
            rows.push_back('{a: AB'(i), d: RB'($urandom), l: (i == 3),
                             rb: '0, clr: 1'b0});
        for (int i = 0; i < 4; i++) rows[i].rb = rows[i].d;
        run_rows(1'b1);
    endtask

    task automatic test_verify;
        rows.delete();
        rows.push_back('{a: 4'd1, d: 8'h3C, l: 1'b0, rb: 8'h3C, clr: 1'b0});
        rows.push_back('{a: 4'd9, d: 8'h3C, l: 1'b0, rb: 8'h3D, clr: 1'b0});
        rows.push_back('{a: 4'd2, d: 8'h55, l: 1'b0, rb: 8'h54, clr: 1'b0});
        rows.push_back('{a: 4'd3, d: 8'h0F, l: 1'b1, rb: 8'h0F, clr: 1'b1});
        run_rows(1'b0);
    endtask

    task automatic test_reset_midop;
        row_t r;
        r = '{a: 4'd3, d: RB'($urandom), l: 1'b1, rb: '0, clr: 1'b0};
        @(negedge C);
        present(r);
        @(negedge C);
        ROW_VALID = 1'b0;
        repeat (SHIFT_CYC + 3) @(negedge C);
        chk("mid_in_pulse", int'({P_STB, P_PV}), 3);
        R_N = 1'b0;
        #1;
        chk("mid_stb_pv", int'({P_STB, P_PV}), 0);
        chk("mid_busy", int'(BUSY), 0);
        chk("mid_ra", int'(P_RA), 0);
        merr = 1'b0;
        mea = '0;
        @(negedge C);
        R_N = 1'b1;
        @(negedge C);
        chk("mid_ready", int'(ROW_READY), 1);
        chk("mid_err", int'({ERR, DONE}), 0);
        rows.delete();
        rows.push_back('{a: 4'd6, d: 8'h96, l: 1'b1, rb: 8'h96, clr: 1'b0});
        run_rows(1'b0);
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_verify;
        test_random;
        test_reset_midop;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
